// File: rtl/ebpc_pkg.sv
// Shared block type and geometry for the EBPC compressed-block datapath.
package ebpc_pkg;

    localparam int unsigned DATA_W     = 8;
    localparam int unsigned BLOCK_SIZE = 4;

    typedef struct packed {
        logic [BLOCK_SIZE-1:0][DATA_W-1:0] px;
    } dbp_block_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first requester after the last-granted index.
module rr_pick #(
    parameter  int unsigned N     = 2,
    localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] last_i,
    output logic             vld_o,
    output logic [IDX_W-1:0] idx_o
);

    logic [IDX_W-1:0] cand;

    // Scan offsets 1..N so the last-granted lane has the lowest priority.
    always_comb begin
        vld_o = 1'b0;
        idx_o = '0;
        cand  = '0;
        for (int unsigned k = 1; k <= N; k++) begin
            cand = IDX_W'((32'(last_i) + k) % N);
            if (!vld_o && req_i[cand]) begin
                vld_o = 1'b1;
                idx_o = cand;
            end
        end
    end

endmodule

// File: rtl/coder_arbiter.sv
// Shares one seq_coder among N_LANES block producers: packet-granular
// round-robin grant, then flush and drain of the coder before the next grant.
module coder_arbiter
    import ebpc_pkg::*;
#(
    parameter  int unsigned N_LANES = 2,
    localparam int unsigned LANE_W  = $clog2(N_LANES)
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  dbp_block_t [N_LANES-1:0] dbp_block_i,
    input  logic [N_LANES-1:0]       last_i,
    input  logic [N_LANES-1:0]       vld_i,
    output logic [N_LANES-1:0]       rdy_o,
    output dbp_block_t               dbp_block_o,
    output logic                     vld_o,
    input  logic                     rdy_i,
    output logic                     flush_o,
    input  logic                     coder_idle_i,
    input  logic                     coder_waiting_i,
    output logic [LANE_W-1:0]        lane_o,
    output logic                     busy_o,
    output logic                     pkt_done_o
);

    typedef enum logic [1:0] {
        ARB   = 2'd0,
        XFER  = 2'd1,
        FLUSH = 2'd2,
        DRAIN = 2'd3
    } state_e;

    localparam int unsigned CNT_W = 16;

    state_e              state_q, state_d;
    logic [LANE_W-1:0]   lane_q, lane_d;
    logic [LANE_W-1:0]   last_grant_q, last_grant_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                done_q, done_d;
    logic                pick_vld;
    logic [LANE_W-1:0]   pick_idx;

    rr_pick #(
        .N (N_LANES)
    ) u_rr_pick (
        .req_i  (vld_i),
        .last_i (last_grant_q),
        .vld_o  (pick_vld),
        .idx_o  (pick_idx)
    );

    // Next-state and datapath steering; everything idles at zero outside XFER.
    always_comb begin
        state_d      = state_q;
        lane_d       = lane_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        done_d       = 1'b0;
        rdy_o        = '0;
        vld_o        = 1'b0;
        dbp_block_o  = '0;
        flush_o      = 1'b0;

        case (state_q)
            ARB: begin
                if (pick_vld) begin
                    lane_d  = pick_idx;
                    state_d = XFER;
                end
            end
            XFER: begin
                vld_o         = vld_i[lane_q];
                dbp_block_o   = dbp_block_i[lane_q];
                rdy_o[lane_q] = rdy_i;
                if (vld_i[lane_q] && rdy_i) begin
                    if (cnt_q != '1) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                    if (last_i[lane_q]) begin
                        state_d = FLUSH;
                    end
                end
            end
            FLUSH: begin
                // Idle is not looked at here; only DRAIN cycles may finish the packet.
                if (coder_waiting_i) begin
                    flush_o = 1'b1;
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (coder_idle_i) begin
                    done_d       = 1'b1;
                    cnt_d        = '0;
                    last_grant_d = lane_q;
                    state_d      = ARB;
                end
            end
            default: state_d = ARB;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= ARB;
            lane_q       <= '0;
            last_grant_q <= LANE_W'(N_LANES - 1);
            cnt_q        <= '0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            lane_q       <= lane_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            done_q       <= done_d;
        end
    end

    assign lane_o     = lane_q;
    assign busy_o     = (state_q != ARB);
    assign pkt_done_o = done_q;

endmodule

// File: tb/tb_coder_arbiter.sv
// Self-checking bench for coder_arbiter: per-lane packet queues, a packet-level
// reference model checked every cycle, plus directed scenario checks.
module tb_coder_arbiter;
    import ebpc_pkg::*;

    localparam int unsigned NL = 2;
    localparam int unsigned LW = $clog2(NL);

    logic              clk     = 1'b0;
    logic              rst_n   = 1'b1;
    dbp_block_t [NL-1:0] blk;
    logic [NL-1:0]     last;
    logic [NL-1:0]     vld;
    logic [NL-1:0]     rdy_o;
    dbp_block_t        blk_o;
    logic              vld_o;
    logic              flush_o;
    logic              busy_o;
    logic              pkt_done_o;
    logic              rdy_i   = 1'b0;
    logic              waiting = 1'b0;
    logic              idle    = 1'b0;
    logic [LW-1:0]     lane_o;

    dbp_block_t lane_blk  [NL];
    logic       lane_vld  [NL];
    logic       lane_last [NL];
    dbp_block_t q_data    [NL][$];
    logic       q_last    [NL][$];

    int force_rdy     = 0;
    int force_waiting = 0;
    int force_idle    = 0;
    bit gate_en       = 1'b0;

    // Reference model: 0 arbitrate, 1 sending, 2 awaiting flush, 3 draining.
    int m_stage = 0;
    int m_lane  = 0;
    int m_prev  = int'(NL) - 1;
    bit m_done  = 1'b0;

    int sc_hs, sc_flush, sc_done, sc_grants, sc_lane_bad;
    int grant_log [$];
    bit busy_seen = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    logic [NL-1:0] e_rdy;
    dbp_block_t    e_blk;

    for (genvar g = 0; g < NL; g++) begin : g_pin
        assign blk[g]  = lane_blk[g];
        assign vld[g]  = lane_vld[g];
        assign last[g] = lane_last[g];
    end

    coder_arbiter #(
        .N_LANES (NL)
    ) u_dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .dbp_block_i     (blk),
        .last_i          (last),
        .vld_i           (vld),
        .rdy_o           (rdy_o),
        .dbp_block_o     (blk_o),
        .vld_o           (vld_o),
        .rdy_i           (rdy_i),
        .flush_o         (flush_o),
        .coder_idle_i    (idle),
        .coder_waiting_i (waiting),
        .lane_o          (lane_o),
        .busy_o          (busy_o),
        .pkt_done_o      (pkt_done_o)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_stage = 0;
        m_lane  = 0;
        m_prev  = int'(NL) - 1;
        m_done  = 1'b0;
    endtask

    // Advance the model by one clock using the inputs presented this cycle.
    task automatic model_step();
        bit found;
        int c;
        found  = 1'b0;
        m_done = 1'b0;
        case (m_stage)
            0: begin
                for (int k = 1; k <= int'(NL); k++) begin
                    c = (m_prev + k) % int'(NL);
                    if (!found && vld[LW'(c)]) begin
                        found   = 1'b1;
                        m_lane  = c;
                        m_stage = 1;
                    end
                end
            end
            1: begin
                if (vld[LW'(m_lane)] && rdy_i) begin
                    if (q_data[LW'(m_lane)].size() > 0) begin
                        void'(q_data[LW'(m_lane)].pop_front());
                        void'(q_last[LW'(m_lane)].pop_front());
                    end
                    if (last[LW'(m_lane)]) m_stage = 2;
                end
            end
            2: if (waiting) m_stage = 3;
            3: begin
                if (idle) begin
                    m_done  = 1'b1;
                    m_prev  = m_lane;
                    m_stage = 0;
                end
            end
            default: m_stage = 0;
        endcase
    endtask

    function automatic bit queues_empty();
        for (int l = 0; l < int'(NL); l++) begin
            if (q_data[LW'(l)].size() != 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic bit quiet();
        return (m_stage == 0) && !m_done && queues_empty();
    endfunction

    task automatic push_pkt(input int lane, input int len);
        for (int i = 0; i < len; i++) begin
            q_data[LW'(lane)].push_back(dbp_block_t'($urandom));
            q_last[LW'(lane)].push_back(i == len - 1);
        end
    endtask

    task automatic clear_obs();
        sc_hs       = 0;
        sc_flush    = 0;
        sc_done     = 0;
        sc_grants   = 0;
        sc_lane_bad = 0;
        grant_log.delete();
    endtask

    task automatic wait_stage(input string tag, input int s, input int budget);
        int n;
        n = 0;
        while (m_stage != s && n < budget) begin
            @(posedge clk);
            n++;
        end
        if (m_stage != s) check_eq(tag, 64'(m_stage), 64'(s));
    endtask

    task automatic wait_quiet(input string tag, input int budget);
        int n;
        n = 0;
        while (!quiet() && n < budget) begin
            @(posedge clk);
            n++;
        end
        if (!quiet()) check_eq(tag, 64'(quiet()), 64'(1));
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    // Producer and coder stimulus, refreshed just after each rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            for (int l = 0; l < int'(NL); l++) begin
                if (q_data[LW'(l)].size() > 0 && (!gate_en || $urandom_range(0, 3) != 0)) begin
                    lane_vld[LW'(l)]  = 1'b1;
                    lane_blk[LW'(l)]  = q_data[LW'(l)][0];
                    lane_last[LW'(l)] = q_last[LW'(l)][0];
                end else begin
                    lane_vld[LW'(l)]  = 1'b0;
                    lane_blk[LW'(l)]  = dbp_block_t'($urandom);
                    lane_last[LW'(l)] = 1'($urandom);
                end
            end
            rdy_i   = (force_rdy < 0)     ? 1'($urandom) : 1'(force_rdy);
            waiting = (force_waiting < 0) ? 1'($urandom) : 1'(force_waiting);
            idle    = (force_idle < 0)    ? 1'($urandom) : 1'(force_idle);
        end
    end

    // Per-cycle comparison against the model, sampled on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) model_reset();
            e_rdy = (m_stage == 1) ? (NL'(rdy_i) << m_lane) : '0;
            e_blk = '0;
            if (m_stage == 1) e_blk = blk[LW'(m_lane)];
            check_eq("busy",  64'(busy_o),     64'(m_stage != 0));
            check_eq("lane",  64'(lane_o),     64'(m_lane));
            check_eq("vld_o", 64'(vld_o),      64'((m_stage == 1) && vld[LW'(m_lane)]));
            check_eq("rdy_o", 64'(rdy_o),      64'(e_rdy));
            check_eq("flush", 64'(flush_o),    64'((m_stage == 2) && waiting));
            check_eq("done",  64'(pkt_done_o), 64'(m_done));
            check_eq("blk_o", 64'(blk_o),      64'(e_blk));
            if (rst_n) begin
                sc_hs    += int'(vld_o & rdy_i);
                sc_flush += int'(flush_o);
                sc_done  += int'(pkt_done_o);
                if (busy_o && lane_o != '0) sc_lane_bad++;
                if (busy_o && !busy_seen) begin
                    sc_grants++;
                    grant_log.push_back(int'(lane_o));
                end
                busy_seen = busy_o;
                model_step();
            end else begin
                busy_seen = 1'b0;
            end
        end
    end

    initial begin
        int l;
        for (int i = 0; i < int'(NL); i++) begin
            lane_vld[LW'(i)]  = 1'b0;
            lane_last[LW'(i)] = 1'b0;
            lane_blk[LW'(i)]  = '0;
        end
        clear_obs();

        // Reset state
        #1 rst_n = 1'b0;
        #2;
        check_eq("rst_busy", 64'(busy_o), 64'(0));
        check_eq("rst_lane", 64'(lane_o), 64'(0));
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;

        // Lane 0, three blocks, coder always ready
        @(posedge clk);
        force_rdy = 1; force_waiting = 1; force_idle = 1; gate_en = 1'b0;
        clear_obs();
        push_pkt(0, 3);
        wait_quiet("a_timeout", 200);
        check_eq("a_hs",       64'(sc_hs),       64'(3));
        check_eq("a_flush",    64'(sc_flush),    64'(1));
        check_eq("a_done",     64'(sc_done),     64'(1));
        check_eq("a_lane_bad", 64'(sc_lane_bad), 64'(0));

        // Both lanes from reset: strict alternation starting at lane 0
        do_reset();
        @(posedge clk);
        clear_obs();
        for (int p = 0; p < 2; p++) begin
            push_pkt(0, int'($urandom_range(1, 3)));
            push_pkt(1, int'($urandom_range(1, 3)));
        end
        wait_quiet("b_timeout", 400);
        check_eq("b_grants", 64'(grant_log.size()), 64'(4));
        for (int i = 0; i < grant_log.size() && i < 4; i++) begin
            check_eq("b_order", 64'(grant_log[i]), 64'(i % 2));
        end

        // Coder stalls for 5 cycles with the last block pending
        @(posedge clk);
        force_rdy = 0;
        clear_obs();
        push_pkt(0, 1);
        wait_stage("c_xfer", 1, 50);
        repeat (4) @(posedge clk);
        #1;
        check_eq("c_busy",  64'(busy_o),   64'(1));
        check_eq("c_vld",   64'(vld_o),    64'(1));
        check_eq("c_hs",    64'(sc_hs),    64'(0));
        check_eq("c_flush", 64'(sc_flush), 64'(0));
        @(posedge clk);
        force_rdy = 1;
        wait_quiet("c_timeout", 100);
        check_eq("c_hs_end",    64'(sc_hs),    64'(1));
        check_eq("c_flush_end", 64'(sc_flush), 64'(1));
        check_eq("c_done_end",  64'(sc_done),  64'(1));

        // Late coder_waiting_i and late coder_idle_i, with lane 0 queued behind
        @(posedge clk);
        force_waiting = 0; force_idle = 0;
        clear_obs();
        push_pkt(1, 1);
        push_pkt(0, 1);
        wait_stage("d_flush_wait", 2, 50);
        clear_obs();
        repeat (3) @(posedge clk);
        #1;
        check_eq("d_flush_pin", 64'(flush_o),  64'(0));
        check_eq("d_flush_cnt", 64'(sc_flush), 64'(0));
        check_eq("d_busy_fl",   64'(busy_o),   64'(1));
        @(posedge clk);
        force_waiting = 1;
        wait_stage("d_drain_wait", 3, 20);
        repeat (9) @(posedge clk);
        #1;
        check_eq("d_busy_dr", 64'(busy_o),    64'(1));
        check_eq("d_nogrant", 64'(sc_grants), 64'(0));
        check_eq("d_flush1",  64'(sc_flush),  64'(1));
        check_eq("d_nodone",  64'(sc_done),   64'(0));
        @(posedge clk);
        force_idle = 1;
        wait_quiet("d_timeout", 100);
        check_eq("d_done_end",   64'(sc_done),   64'(2));
        check_eq("d_flush_end",  64'(sc_flush),  64'(2));
        check_eq("d_grants_end", 64'(sc_grants), 64'(1));
        if (grant_log.size() > 0) check_eq("d_next_lane", 64'(grant_log[0]), 64'(0));

        // Reset while lane 1 drains
        do_reset();
        @(posedge clk);
        force_idle = 0; force_waiting = 1; force_rdy = 1;
        clear_obs();
        push_pkt(1, 1);
        wait_stage("e_drain_wait", 3, 50);
        #1;
        check_eq("e_lane1", 64'(lane_o), 64'(1));
        push_pkt(0, 2);
        push_pkt(1, 2);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_eq("e_rdy0",   64'(rdy_o),      64'(0));
        check_eq("e_vld0",   64'(vld_o),      64'(0));
        check_eq("e_flush0", 64'(flush_o),    64'(0));
        check_eq("e_busy0",  64'(busy_o),     64'(0));
        check_eq("e_done0",  64'(pkt_done_o), 64'(0));
        check_eq("e_lane0",  64'(lane_o),     64'(0));
        check_eq("e_blk0",   64'(blk_o),      64'(0));
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        force_idle = 1;
        wait_stage("e_grant_wait", 1, 50);
        #1;
        check_eq("e_first_lane", 64'(lane_o), 64'(0));
        @(posedge clk);
        wait_quiet("e_timeout", 200);

        // Randomised traffic with gated valids, random coder handshakes and a mid-run reset
        @(posedge clk);
        gate_en = 1'b1; force_rdy = -1; force_waiting = -1; force_idle = -1;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            @(posedge clk);
            if ($urandom_range(0, 5) == 0) begin
                l = int'($urandom_range(0, NL - 1));
                if (q_data[LW'(l)].size() < 12) push_pkt(l, int'($urandom_range(1, 5)));
            end
            if (cyc == 800) do_reset();
        end
        wait_quiet("f_timeout", 3000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/coder_arbiter.md
CODER_ARBITER -- requirements
Module: coder_arbiter

Interface
REQ-001 SHALL have parameter N_LANES, default 2, number of block producers sharing one seq_coder (2..8).
REQ-002 SHALL have port clk_i  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port rst_ni  input  1  asynchronous active-low reset.
REQ-004 SHALL have port dbp_block_i  input  N_LANES x dbp_block_t  per-lane block data.
REQ-005 SHALL have port last_i  input  N_LANES  per-lane "final block of packet" flag.
REQ-006 SHALL have port vld_i  input  N_LANES  per-lane block valid.
REQ-007 SHALL have port rdy_o  output  N_LANES  per-lane block ready.
REQ-008 SHALL have port dbp_block_o  output  dbp_block_t  block to seq_coder.
REQ-009 SHALL have port vld_o  output  1  block valid to seq_coder.
REQ-010 SHALL have port rdy_i  input  1  seq_coder block ready.
REQ-011 SHALL have port flush_o  output  1  flush request to seq_coder.
REQ-012 SHALL have port coder_idle_i  input  1  seq_coder idle (fully drained).
REQ-013 SHALL have port coder_waiting_i  input  1  seq_coder input slice empty.
REQ-014 SHALL have port lane_o  output  $clog2(N_LANES)  index of the lane currently owning the coder.
REQ-015 SHALL have port busy_o  output  1  high in every state except ARB.
REQ-016 SHALL have port pkt_done_o  output  1  one-cycle pulse when a packet has been fully flushed.

Function
REQ-017 SHALL implement four states: ARB, XFER, FLUSH, DRAIN.
REQ-018 In ARB, all rdy_o, vld_o and flush_o SHALL be 0.
REQ-019 In ARB, when any vld_i is high, the controller SHALL select round-robin, starting at the lane after the last-granted lane, and register the winner into lane_o with a transition to XFER on the next edge (one-cycle arbitration latency).
REQ-020 In XFER, dbp_block_o and vld_o SHALL be combinationally driven from the granted lane.
REQ-021 In XFER, rdy_o[lane_o] SHALL equal rdy_i and all other rdy_o bits SHALL be 0.
REQ-022 In XFER, a handshake (vld_o & rdy_i) SHALL increment an internal block counter, 16-bit, saturating at 0xFFFF.
REQ-023 A handshake with last_i[lane_o]=1 SHALL move the controller to FLUSH.
REQ-024 If the granted lane drops vld_i in XFER, the controller SHALL keep the grant; there is no preemption mid-packet.
REQ-025 In FLUSH, flush_o SHALL pulse high for exactly one cycle, in the first cycle in which coder_waiting_i=1, and the controller SHALL then move to DRAIN.
REQ-026 In DRAIN, flush_o SHALL be 0; the controller SHALL remain in DRAIN until coder_idle_i=1 is sampled, then pulse pkt_done_o, clear the block counter, record lane_o as last-granted, and return to ARB.
REQ-027 coder_idle_i SHALL be ignored in the flush-pulse cycle itself; only DRAIN cycles count.
REQ-028 Simultaneous requests SHALL be granted by round-robin order only; a single requesting lane SHALL be re-granted after every packet.
REQ-029 The next grant SHALL never start before the previous packet's DRAIN completes; minimum gap between packets is ARB(1) + FLUSH(>=1) + DRAIN(>=1) cycles.
REQ-030 A single-block packet (last_i on the first handshake) SHALL go XFER -> FLUSH directly.

Reset
REQ-031 Asserting rst_ni low SHALL, at any time including mid-packet or mid-flush, force: state ARB, lane_o 0, last-granted lane N_LANES-1 (so lane 0 wins first), block counter 0, all rdy_o/vld_o/flush_o/busy_o/pkt_done_o 0.
REQ-032 dbp_block_o SHALL be 0 whenever the state is not XFER.

Structure
REQ-033 dbp_block_t, DATA_W and BLOCK_SIZE SHALL come from ebpc_pkg.
REQ-034 The state enum SHALL be declared locally in the module.
REQ-035 Round-robin selection SHALL be a combinational sub-module rr_pick with inputs req and last-granted index, and outputs a valid flag and the winner index.

Verification
REQ-036 Bench SHALL cover: lane0 sends 3 blocks with last on the 3rd, coder always ready -> 3 handshakes, one flush_o pulse, pkt_done_o once, lane_o=0 throughout.
REQ-037 Bench SHALL cover: both lanes request from reset -> lane 0 is granted first, then lane 1, then lane 0 again (strict alternation over 4 packets).
REQ-038 Bench SHALL cover: rdy_i held low for 5 cycles during XFER with the last block pending -> the controller stays in XFER, no flush, and the block is accepted when rdy_i rises.
REQ-039 Bench SHALL cover: coder_waiting_i low for 4 cycles in FLUSH -> flush_o stays 0 until coder_waiting_i rises, then exactly one pulse; coder_idle_i delayed 10 cycles -> busy_o stays high, with no new grant.
REQ-040 Bench SHALL cover: rst_ni asserted in DRAIN with lane 1 granted -> all outputs 0 immediately; after release, lane 0 is granted first.
